// File: rtl/ocx_dlx_tx_beat_que_if.sv
// Framer-to-queue handshake plus gearbox-side beat, sequence and status signals.
// The queue itself connects through the slave modport.
interface ocx_dlx_tx_beat_que_if;
  logic [63:0] fr_que_data;
  logic        fr_que_valid;
  logic        que_fr_ready;
  logic        ctl_que_run;
  logic        ctl_que_flush;
  logic [6:0]  ctl_gb_seq;
  logic        ctl_gb_stall;
  logic [63:0] que_gb_data;
  logic        que_gb_odd;
  logic        que_err_underrun;

  modport master (
    output fr_que_data, fr_que_valid, ctl_que_run, ctl_que_flush,
    input  que_fr_ready, ctl_gb_seq, ctl_gb_stall, que_gb_data, que_gb_odd, que_err_underrun
  );

  modport slave (
    input  fr_que_data, fr_que_valid, ctl_que_run, ctl_que_flush,
    output que_fr_ready, ctl_gb_seq, ctl_gb_stall, que_gb_data, que_gb_odd, que_err_underrun
  );
endinterface

// File: rtl/ocx_dlx_tx_beat_que.sv
// 4-deep TX beat queue and 66-state gearbox sequencer; a written beat reaches head on the next advance.
// Ready drops only when full; the two header-slot stalls per 66 cycles hold head and let the queue fill.
module ocx_dlx_tx_beat_que (
  input  logic                        dlx_clk,
  input  logic                        dlx_reset,
  ocx_dlx_tx_beat_que_if.slave        bus
);

  logic [6:0]  seq_q;
  logic [63:0] mem_q [4];
  logic [1:0]  rd_ptr_q;
  logic [1:0]  wr_ptr_q;
  logic [2:0]  count_q;
  logic [63:0] head_q;
  logic        odd_q;
  logic        underrun_q;

  logic        stall;
  logic        empty;
  logic        adv;
  logic        push;
  logic        pop;
  logic [63:0] head_nxt;

  assign stall    = (seq_q[6:1] == 6'd32);
  assign empty    = (count_q == 3'd0);
  assign adv      = bus.ctl_que_run & ~stall;
  assign push     = bus.fr_que_valid & bus.que_fr_ready & ~bus.ctl_que_flush;
  assign pop      = adv & ~empty & ~bus.ctl_que_flush;
  // Head only ever sees registered FIFO contents, so a same-cycle write is never bypassed.
  assign head_nxt = empty ? 64'h0 : mem_q[rd_ptr_q];

  assign bus.que_fr_ready     = ~dlx_reset & (count_q != 3'd4);
  assign bus.ctl_gb_seq       = seq_q;
  assign bus.ctl_gb_stall     = stall;
  assign bus.que_gb_data      = head_q;
  assign bus.que_gb_odd       = odd_q;
  assign bus.que_err_underrun = underrun_q;

  // The sequence runs regardless of run/flush so training sees a live gearbox count.
  always_ff @(posedge dlx_clk) begin
    if (dlx_reset)            seq_q <= 7'd0;
    else if (seq_q == 7'd65)  seq_q <= 7'd0;
    else                      seq_q <= seq_q + 7'd1;
  end

  always_ff @(posedge dlx_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.fr_que_data;
  end

  always_ff @(posedge dlx_clk) begin
    if (dlx_reset || bus.ctl_que_flush) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      head_q   <= 64'h0;
      odd_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
      if (adv) begin
        head_q <= head_nxt;
        odd_q  <= ^head_nxt;
      end
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge dlx_clk) begin
    if (dlx_reset)                                 underrun_q <= 1'b0;
    else if (adv && empty && !bus.ctl_que_flush)   underrun_q <= 1'b1;
  end

endmodule

// File: tb/tb_ocx_dlx_tx_beat_que.sv
// Randomized and directed stimulus against a queue-based reference model with a decoupled scoreboard.
module tb_ocx_dlx_tx_beat_que;
  logic dlx_clk = 1'b0;
  logic dlx_reset;
  ocx_dlx_tx_beat_que_if bus ();

  ocx_dlx_tx_beat_que dut (
    .dlx_clk   (dlx_clk),
    .dlx_reset (dlx_reset),
    .bus       (bus.slave)
  );

  always #5 dlx_clk = ~dlx_clk;

  int ncmp = 0;
  int nerr = 0;

  logic [63:0] mfifo [$];
  logic [63:0] exp_q [$];
  int          mseq = 0;
  bit          munder = 1'b0;

  bit          win = 1'b0;
  int          adv_in_win = 0;
  int          rdy_low_in_win = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: beats are a list; each advance takes the oldest or yields zero.
  always @(posedge dlx_clk) begin
    bit          rdy;
    bit          madv;
    logic [63:0] v;
    rdy = !dlx_reset && (mfifo.size() < 4);
    if (dlx_reset) begin
      mseq = 0;
      munder = 1'b0;
      mfifo.delete();
      exp_q.delete();
      exp_q.push_back(64'h0);
    end else begin
      madv = bus.ctl_que_run && (mseq < 64);
      if (bus.ctl_que_flush) begin
        mfifo.delete();
        exp_q.push_back(64'h0);
      end else begin
        if (madv) begin
          if (mfifo.size() > 0) v = mfifo.pop_front();
          else begin
            v = 64'h0;
            munder = 1'b1;
          end
          exp_q.push_back(v);
        end
        if (bus.fr_que_valid && rdy) mfifo.push_back(bus.fr_que_data);
      end
      mseq = (mseq == 65) ? 0 : mseq + 1;
    end
  end

  // Monitor: whenever the DUT took a new head value, pop the scoreboard and compare.
  logic [63:0] cur_exp = 64'h0;
  bit          stall_rec = 1'b0;
  always @(posedge dlx_clk) begin
    bit upd;
    #2;
    upd = dlx_reset || bus.ctl_que_flush || (bus.ctl_que_run && !stall_rec);
    if (upd) begin
      if (exp_q.size() == 0) begin
        nerr++;
        ncmp++;
        $display("FAIL scoreboard_empty: DUT updated head, no expected beat (t=%0t)", $time);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    if (win && bus.ctl_que_run && !stall_rec && !dlx_reset) adv_in_win++;
    if (win && !bus.que_fr_ready) rdy_low_in_win++;
    chk("head", bus.que_gb_data, cur_exp);
    chk("odd", {63'h0, bus.que_gb_odd}, {63'h0, ^cur_exp});
    chk("seq", {57'h0, bus.ctl_gb_seq}, 64'(mseq));
    chk("stall", {63'h0, bus.ctl_gb_stall}, {63'h0, (mseq >= 64)});
    chk("ready", {63'h0, bus.que_fr_ready}, {63'h0, (!dlx_reset && mfifo.size() < 4)});
    chk("underrun", {63'h0, bus.que_err_underrun}, {63'h0, munder});
    stall_rec = bus.ctl_gb_stall;
  end

  task automatic cyc(input bit v, input logic [63:0] d, input bit r, input bit f, input bit rs);
    bus.fr_que_valid  = v;
    bus.fr_que_data   = d;
    bus.ctl_que_run   = r;
    bus.ctl_que_flush = f;
    dlx_reset         = rs;
    @(negedge dlx_clk);
  endtask

  task automatic wait_seq(input int s);
    int n = 0;
    while (mseq != s && n < 200) begin
      @(negedge dlx_clk);
      n++;
    end
    if (n >= 200) begin
      nerr++;
      ncmp++;
      $display("FAIL wait_seq: sequence never reached %0d", s);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // Reset, then free-running sequence with run low through a full wrap.
    repeat (3) cyc(0, 64'h0, 0, 0, 1);
    repeat (70) cyc(0, 64'h0, 0, 0, 0);

    // Three back-to-back beats from seq 10 with run high.
    wait_seq(10);
    cyc(1, 64'h1, 1, 0, 0);
    cyc(1, 64'h3, 1, 0, 0);
    cyc(1, 64'h7, 1, 0, 0);
    repeat (6) cyc(0, 64'h0, 1, 0, 0);
    cyc(0, 64'h0, 1, 1, 0);
    repeat (3) cyc(0, 64'h0, 1, 0, 0);

    // Continuous valid across the stall slots; 660 cycles must yield 640 advances.
    repeat (2) cyc(0, 64'h0, 0, 0, 1);
    repeat (2) cyc(1, rnd64(), 0, 0, 0);
    win = 1'b1;
    repeat (660) cyc(1, rnd64(), 1, 0, 0);
    win = 1'b0;
    chk("throughput_advances", 64'(adv_in_win), 64'd640);
    chk("ready_low_during_stall", {63'h0, (rdy_low_in_win > 0)}, 64'h1);
    chk("no_underrun_steady", {63'h0, bus.que_err_underrun}, 64'h0);

    // Flush with three queued beats and a same-cycle write, then drain into underrun.
    cyc(0, 64'h0, 0, 1, 0);
    repeat (3) cyc(1, rnd64(), 0, 0, 0);
    cyc(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0);
    repeat (2) cyc(0, 64'h0, 0, 0, 0);
    repeat (4) cyc(0, 64'h0, 1, 0, 0);
    cyc(0, 64'h0, 1, 1, 0);
    repeat (2) cyc(0, 64'h0, 0, 0, 0);

    // Reset pulse at seq 40 with two beats queued.
    cyc(0, 64'h0, 0, 0, 1);
    cyc(0, 64'h0, 0, 0, 0);
    wait_seq(38);
    repeat (2) cyc(1, rnd64(), 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 1);
    repeat (3) cyc(0, 64'h0, 0, 0, 0);

    // Random traffic.
    repeat (1500) begin
      cyc(($urandom_range(0, 9) < 7), rnd64(), ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 1));
    end
    repeat (3) cyc(0, 64'h0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
